// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and sizes for the data-memory access path.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/access_counter.sv
`default_nettype none
// ============================================================================
// Module      : access_counter
// Description : Up-counter with synchronous clear, count enable and a
//               terminal-count flag. Shared by the memory access controllers.
// Revision    : 1.0 - initial release
// ============================================================================
module access_counter #(
  parameter int WIDTH    = 2,
  parameter int TERMINAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  // Clear has priority so a fresh access always starts its window at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Terminal flag marks the last cycle of the access window.
  always_comb begin
    terminal = (count == WIDTH'(TERMINAL));
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Multi-cycle access controller between the EX/MEM register and
//               the data memory. Latches one request, holds address/data for
//               LATENCY cycles, commits a store exactly once, captures load
//               data and freezes the pipeline until the access completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              freeze,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  // Reject out-of-range window lengths at elaboration.
  generate
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("mem_access_ctrl: LATENCY out of range");
    end
  endgenerate

  mem_state_t        state;
  mem_state_t        next_state;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic              cnt_clear;
  logic              cnt_en;
  logic              latch_req;
  logic              capture;
  logic              op_read;
  logic              op_write;
  logic              misalign_q;

  access_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (LATENCY - 1)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .count    (cnt),
    .terminal (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. The reset term on the IDLE request keeps
  // freeze low while reset is held, so every output reads zero in reset.
  always_comb begin
    next_state = state;
    freeze     = 1'b0;
    ready      = 1'b0;
    misalign   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    latch_req  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (rst && (req_read || req_write)) begin
          freeze     = 1'b1;
          latch_req  = 1'b1;
          cnt_clear  = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        freeze   = 1'b1;
        cnt_en   = 1'b1;
        mem_read = op_read;
        if (cnt_last) begin
          // Write enable only on the final window cycle: one commit edge.
          mem_write  = op_write;
          capture    = op_read;
          next_state = DONE;
        end
      end
      DONE: begin
        // Requests seen here are the old one still held upstream; ignore.
        ready      = 1'b1;
        misalign   = misalign_q;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch and load-data capture; rdata persists across stores/idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      op_read    <= 1'b0;
      op_write   <= 1'b0;
      misalign_q <= 1'b0;
      rdata      <= '0;
    end else begin
      if (latch_req) begin
        mem_addr   <= req_addr;
        mem_wdata  <= req_wdata;
        // A simultaneous read+write is a store; no load data is captured.
        op_read    <= req_read & ~req_write;
        op_write   <= req_write;
        misalign_q <= |req_addr[1:0];
      end
      if (capture) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire
